manchester_decoder: RTL
=======================

Name: manchester_decoder

Overview:
- Receive-side counterpart of the team's Manchester encoder. Recovers the bit stream from an asynchronous Manchester line sampled by the local clock.
- Bit convention: 1 = high-to-low mid-bit transition; 0 = low-to-high mid-bit transition.
- Acquires bit-phase lock from edge spacing and emits one decoded bit per bit period with a valid pulse.
- Flags loss of lock.

Parameters:
- SAMPLES_PER_BIT, 16: clk cycles per Manchester bit period. Must be even and ≥ 8.
- T_LO, 3*SAMPLES_PER_BIT/4 (integer division, derived): minimum accepted mid-bit edge spacing.
- T_HI, 5*SAMPLES_PER_BIT/4 (integer division, derived): maximum accepted mid-bit edge spacing.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- manchester_in  input  1  encoded line, asynchronous to clk
- data_out  output  1  last decoded bit; holds between bits
- data_valid  output  1  one-cycle pulse when data_out updates
- locked  output  1  high while bit phase is locked
- sync_err  output  1  one-cycle pulse on loss of lock

Behaviour:
- Reset (synchronous, active-high): all outputs 0, synchronizer flops 0, counter 0, state HUNT_IDLE. Reset asserted mid-frame: outputs are 0 on the next edge, and acquisition restarts from scratch.
- Input path: 2-flop synchronizer s1 → s2, plus a history flop s3. edge = s2 ^ s3. rise = s2 & ~s3.
- Counter cnt: width $clog2(2*SAMPLES_PER_BIT)+1. Increments every cycle and saturates at max. Cleared to 0 on every accepted reference edge.
- HUNT_IDLE: wait for edge. On edge: cnt ← 0, go to HUNT_MEAS.
- HUNT_MEAS: on edge with cnt < T_LO, treat it as the new reference (cnt ← 0, stay).
  - On edge with T_LO ≤ cnt ≤ T_HI: this edge is a mid-bit edge. data_out ← ~rise (rising edge gives 0, falling edge gives 1), data_valid ← 1, locked ← 1, cnt ← 0, go to LOCKED.
  - cnt > T_HI with no edge: go to HUNT_IDLE. No sync_err is raised.
- LOCKED:
  - First edge with cnt < T_LO: boundary edge, ignored.
  - Second edge with cnt < T_LO in the same bit: glitch. sync_err ← 1, locked ← 0, go to HUNT_IDLE.
  - Edge with T_LO ≤ cnt ≤ T_HI: decode as above, data_valid ← 1, cnt ← 0.
  - cnt reaches T_HI+1 with no qualifying edge: sync_err ← 1, locked ← 0, go to HUNT_IDLE.
- Boundary rule: an edge at exactly cnt == T_LO or cnt == T_HI is accepted.
- Latency: a line transition first sampled by s1 on clk edge k produces data_valid high in the cycle after edge k+3 (fixed at 3 clk).
- data_valid and sync_err are never high in the same cycle. Both deassert the cycle after they pulse.
- locked stays high across the cycle of a data_valid pulse. It falls in the same cycle sync_err pulses.
- The first bit after idle is consumed by acquisition and is not emitted.

Test Plan (SAMPLES_PER_BIT=16, so T_LO=12, T_HI=20):
1. Reset check: assert rst for 2 cycles with the line toggling → data_out, data_valid, locked and sync_err all 0; state re-enters HUNT_IDLE.
2. Acquisition and decode: idle low, then encode bits 1,0,1,1,0,0 at 16 cycles/bit → decoder emits 0,1,1,0,0.
   - data_valid pulses are exactly 16 cycles apart.
   - Each pulse comes 3 cycles after its mid-bit transition.
   - locked rises with the first pulse.
3. Loss of signal: after lock, hold the line constant → sync_err pulses once when cnt reaches 21; locked falls in the same cycle; no further data_valid.
4. Jitter tolerance: after lock, mid-bit edge spacings of 12 then 20 → both bits decode. Spacing 21 → sync_err and no data_valid for that bit.
5. Glitch: after lock, inject two edges 3 cycles apart early in a bit (cnt < 12) → sync_err pulses and locked drops. Clean traffic afterwards reacquires lock within 2 bit periods.
6. Reset mid-frame: assert rst for 1 cycle during locked decoding of an alternating 1/0 stream → all outputs 0 on the next edge. Lock re-acquires, and the first emitted bit matches the encoded stream.

Source files
------------

// File: rtl/manchester_decoder.sv
// rtl/manchester_decoder.sv - Manchester line decoder: edge-spacing bit-phase lock, one decoded bit per period
module manchester_decoder #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic manchester_in,
  output logic data_out,
  output logic data_valid,
  output logic locked,
  output logic sync_err
);

  localparam int T_LO  = 3 * SAMPLES_PER_BIT / 4;
  localparam int T_HI  = 5 * SAMPLES_PER_BIT / 4;
  localparam int CNT_W = $clog2(2 * SAMPLES_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] T_LO_C  = CNT_W'(T_LO);
  localparam logic [CNT_W-1:0] T_HI_C  = CNT_W'(T_HI);

  typedef enum logic [1:0] {
    HUNT_IDLE,
    HUNT_MEAS,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             edge_q, edge_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bnd_q, bnd_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      edge_q       <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= '0;
      bnd_q        <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      edge_q       <= edge_d;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
      bnd_q        <= bnd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // cnt_inc is the number of cycles since the last reference edge, as seen in this cycle.
  always_comb begin
    s1_d    = manchester_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    edge_d  = s2_q ^ s3_q;
    rise_d  = s2_q & ~s3_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    bnd_d        = bnd_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;

    case (state_q)
      HUNT_IDLE: begin
        locked_d = 1'b0;
        if (edge_q) begin
          cnt_d   = '0;
          state_d = HUNT_MEAS;
        end
      end

      HUNT_MEAS: begin
        if (edge_q) begin
          cnt_d = '0;
          if (cnt_inc >= T_LO_C && cnt_inc <= T_HI_C) begin
            data_out_d   = ~rise_q;
            data_valid_d = 1'b1;
            locked_d     = 1'b1;
            bnd_d        = 1'b0;
            state_d      = LOCKED;
          end
        end else if (cnt_inc > T_HI_C) begin
          state_d = HUNT_IDLE;
        end
      end

      LOCKED: begin
        // An edge arriving past T_HI is not a qualifying edge, so timeout wins.
        if (cnt_inc > T_HI_C) begin
          sync_err_d = 1'b1;
          locked_d   = 1'b0;
          state_d    = HUNT_IDLE;
        end else if (edge_q) begin
          if (cnt_inc < T_LO_C) begin
            if (bnd_q) begin
              sync_err_d = 1'b1;
              locked_d   = 1'b0;
              state_d    = HUNT_IDLE;
            end else begin
              bnd_d = 1'b1;
            end
          end else begin
            data_out_d   = ~rise_q;
            data_valid_d = 1'b1;
            bnd_d        = 1'b0;
            cnt_d        = '0;
          end
        end
      end

      default: begin
        state_d  = HUNT_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule
